// File: rtl/id_pkg.sv
// Shared definitions for the identifier transmitter and recognizer:
// character class ranges, class encoding and transmitter state encoding.
package id_pkg;

  // ASCII ranges for the character classes
  localparam logic [7:0] LETTER_UC_LO = 8'd65;
  localparam logic [7:0] LETTER_UC_HI = 8'd90;
  localparam logic [7:0] LETTER_LC_LO = 8'd97;
  localparam logic [7:0] LETTER_LC_HI = 8'd122;
  localparam logic [7:0] DIGIT_LO     = 8'd48;
  localparam logic [7:0] DIGIT_HI     = 8'd57;

  // 2-bit character class encoding
  typedef logic [1:0] cls_t;
  localparam cls_t CLS_OTHER  = 2'd0;
  localparam cls_t CLS_LETTER = 2'd1;
  localparam cls_t CLS_DIGIT  = 2'd2;

  // Transmitter state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_SEPR = 2'd2;

endpackage

// File: rtl/char_class.sv
// Combinational ASCII classifier shared by both ends of the identifier link,
// so transmitter and recognizer always agree on what a letter or digit is.
module char_class
  import id_pkg::*;
(
  input  logic [7:0] ch,
  output logic [1:0] cls
);

  // Map the character onto letter / digit / other
  always_comb begin
    cls = CLS_OTHER;
    if ((ch >= LETTER_UC_LO && ch <= LETTER_UC_HI) ||
        (ch >= LETTER_LC_LO && ch <= LETTER_LC_HI))
      cls = CLS_LETTER;
    else if (ch >= DIGIT_LO && ch <= DIGIT_HI)
      cls = CLS_DIGIT;
  end

endmodule

// File: rtl/id_tx.sv
// Identifier transmitter: a host loads up to DEPTH chars, then the buffer is
// streamed on a valid/ready link followed by one separator char. A running
// flag tracks whether the loaded string is a legal identifier.
module id_tx
  import id_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] SEP_CHAR = 8'd32,
  localparam int        CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_char,
  input  logic          start,
  input  logic          ready,
  output logic [7:0]    char,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic          is_id,
  output logic [CW-1:0] count
);

  localparam int IW = $clog2(DEPTH);

  logic [1:0]    state;
  logic [CW-1:0] count_q;
  logic [IW-1:0] idx;
  logic [7:0]    char_q;
  logic          valid_q;
  logic          done_q;
  logic          is_id_q;
  logic [7:0]    mem [DEPTH];

  logic [1:0]    wr_cls;
  logic          beat;
  logic          last;
  logic          go;
  logic          wr_ok;

  char_class u_class (
    .ch  (wr_char),
    .cls (wr_cls)
  );

  // valid/char come straight from registers; ready only steers the next state
  assign beat  = valid_q & ready;
  assign last  = (CW'(idx) == count_q - CW'(1));
  assign go    = (state == ST_IDLE) && start && (count_q != '0);
  // start wins over a same-cycle write, and writes past DEPTH are dropped
  assign wr_ok = (state == ST_IDLE) && wr_en && !start && (count_q < CW'(DEPTH));

  // Buffer storage: written only while idle, frozen during transmission
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[count_q[IW-1:0]] <= wr_char;
  end

  // Load / send / separator control
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count_q <= '0;
      idx     <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      is_id_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state   <= ST_SEND;
            idx     <= '0;
            valid_q <= 1'b1;
            char_q  <= mem[0];
          end else if (wr_ok) begin
            count_q <= count_q + CW'(1);
            if (count_q == '0)
              is_id_q <= (wr_cls == CLS_LETTER);
            else
              is_id_q <= is_id_q & (wr_cls != CLS_OTHER);
          end
        end
        ST_SEND: begin
          if (beat) begin
            if (last) begin
              state  <= ST_SEPR;
              char_q <= SEP_CHAR;
            end else begin
              idx    <= idx + IW'(1);
              char_q <= mem[idx + IW'(1)];
            end
          end
        end
        ST_SEPR: begin
          if (beat) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            char_q  <= '0;
            done_q  <= 1'b1;
            count_q <= '0;
            idx     <= '0;
            is_id_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign char  = char_q;
  assign valid = valid_q;
  assign busy  = (state != ST_IDLE);
  assign done  = done_q;
  assign full  = (count_q == CW'(DEPTH));
  assign is_id = is_id_q;
  assign count = count_q;

endmodule

// File: tb/tb_id_tx.sv
// Self-checking bench for id_tx: expected chars are queued when a send is
// started and compared against every accepted beat by a negedge monitor.
module tb_id_tx;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_char;
  logic          start;
  logic          ready;
  logic [7:0]    char_o;
  logic          valid;
  logic          busy;
  logic          done;
  logic          full;
  logic          is_id;
  logic [CW-1:0] count;

  int errs   = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [7:0] sb_q[$];
  logic [7:0] mdl_q[$];
  bit         mdl_id;

  id_tx #(.DEPTH(DEPTH), .SEP_CHAR(8'd32)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_char (wr_char),
    .start   (start),
    .ready   (ready),
    .char    (char_o),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .full    (full),
    .is_id   (is_id),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit m_letter(input logic [7:0] c);
    return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122);
  endfunction

  function automatic bit m_digit(input logic [7:0] c);
    return (c >= 8'd48 && c <= 8'd57);
  endfunction

  // Scoreboard monitor: every accepted beat must match the next expected char
  always @(negedge clk) begin
    if (!reset && valid && ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_beat", {24'd0, char_o}, 32'hFFFF);
      end else begin
        chk("sb_char", {24'd0, char_o}, {24'd0, sb_q.pop_front()});
      end
    end
    if (done) done_cnt++;
  end

  // All tasks start and end at posedge+1
  task automatic wr(input logic [7:0] c);
    wr_en = 1'b1;
    wr_char = c;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (mdl_q.size() < DEPTH) begin
      if (mdl_q.size() == 0) mdl_id = m_letter(c);
      else                   mdl_id = mdl_id & (m_letter(c) | m_digit(c));
      mdl_q.push_back(c);
    end
    chk("wr_count", {28'd0, count}, mdl_q.size());
    chk("wr_is_id", {31'd0, is_id}, {31'd0, mdl_id});
    chk("wr_full", {31'd0, full}, (mdl_q.size() == DEPTH) ? 1 : 0);
  endtask

  task automatic send();
    foreach (mdl_q[i]) sb_q.push_back(mdl_q[i]);
    sb_q.push_back(8'd32);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mdl_q.delete();
    mdl_id = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("done_timeout", {31'd0, seen}, 1);
    chk("post_count", {28'd0, count}, 0);
    chk("post_is_id", {31'd0, is_id}, 0);
    chk("post_busy", {31'd0, busy}, 0);
    chk("sb_empty", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    logic [7:0] bp_rdy [6];
    logic [7:0] bp_chr [6];
    bp_rdy = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
    bp_chr = '{8'd120, 8'd120, 8'd121, 8'd121, 8'd121, 8'd32};

    reset = 1'b1; wr_en = 1'b0; wr_char = '0; start = 1'b0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_count", {28'd0, count}, 0);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_is_id", {31'd0, is_id}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_char", {24'd0, char_o}, 0);

    // "a1" with exact cycle timing
    wr(8'd97); wr(8'd49);
    chk("a1_is_id", {31'd0, is_id}, 1);
    d0 = done_cnt;
    send();
    chk("a1_c0_valid", {31'd0, valid}, 1);
    chk("a1_c0", {24'd0, char_o}, 97);
    @(posedge clk); #1;
    chk("a1_c1_valid", {31'd0, valid}, 1);
    chk("a1_c1", {24'd0, char_o}, 49);
    @(posedge clk); #1;
    chk("a1_sep_valid", {31'd0, valid}, 1);
    chk("a1_sep", {24'd0, char_o}, 32);
    @(posedge clk); #1;
    chk("a1_done", {31'd0, done}, 1);
    chk("a1_valid_off", {31'd0, valid}, 0);
    chk("a1_count", {28'd0, count}, 0);
    @(posedge clk); #1;
    chk("a1_done_once", done_cnt - d0, 1);
    chk("a1_sb_empty", sb_q.size(), 0);

    // Non-identifiers still transmit
    wr(8'd49); wr(8'd97);
    chk("1a_is_id", {31'd0, is_id}, 0);
    send(); wait_done(20);
    wr(8'd65); wr(8'd36);
    chk("A$_is_id", {31'd0, is_id}, 0);
    send(); wait_done(20);

    // Backpressure on "xy"
    wr(8'd120); wr(8'd121);
    ready = 1'b0;
    send();
    for (int i = 0; i < 6; i++) begin
      ready = bp_rdy[i][0];
      chk("bp_valid", {31'd0, valid}, 1);
      chk("bp_char", {24'd0, char_o}, {24'd0, bp_chr[i]});
      @(posedge clk); #1;
    end
    ready = 1'b1;
    wait_done(4);

    // Overflow: nine writes, eight kept
    for (int i = 0; i < 9; i++) wr(8'(65 + i));
    chk("ovf_count", {28'd0, count}, DEPTH);
    chk("ovf_full", {31'd0, full}, 1);
    send(); wait_done(30);

    // Start on empty buffer is ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("empty_start_busy", {31'd0, busy}, 0);
    chk("empty_start_valid", {31'd0, valid}, 0);

    // Start wins over a same-cycle write
    wr(8'd113);
    sb_q.push_back(8'd113);
    sb_q.push_back(8'd32);
    mdl_q.delete();
    start = 1'b1; wr_en = 1'b1; wr_char = 8'd122;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    chk("prio_busy", {31'd0, busy}, 1);
    chk("prio_count", {28'd0, count}, 1);
    wait_done(20);

    // Reset on the second beat of a three-char send
    wr(8'd97); wr(8'd98); wr(8'd99);
    d0 = done_cnt;
    send();
    @(posedge clk); #1;
    chk("rstmid_char", {24'd0, char_o}, 98);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_valid", {31'd0, valid}, 0);
    chk("rstmid_busy", {31'd0, busy}, 0);
    chk("rstmid_count", {28'd0, count}, 0);
    sb_q.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_no_done", done_cnt - d0, 0);
    wr(8'd111); wr(8'd107);
    chk("fresh_is_id", {31'd0, is_id}, 1);
    send(); wait_done(20);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/id_tx.md
Name: id_tx

Overview:
- Transmit-side counterpart of the identifier recognizer.
- Buffers up to DEPTH characters written by a host, then streams them one char per accepted beat on a valid/ready interface, followed by one separator char.
- While loading, it keeps a running flag saying whether the buffered string is a legal identifier: a letter first, then letters or digits.
- Sits upstream of the recognizer, so the recognizer can be driven from a host-loaded string.

Parameters:
- DEPTH, 8: maximum buffered chars; must be at least 2.
- SEP_CHAR, 8'd32: char appended after the last buffered char (space).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  append wr_char to the buffer.
- wr_char  in  8  ASCII char to append.
- start  in  1  begin transmission of the buffer.
- ready  in  1  downstream accepts char this cycle.
- char  out  8  current output char.
- valid  out  1  char is valid.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the separator is accepted.
- full  out  1  count equals DEPTH.
- is_id  out  1  buffer holds a legal identifier; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of buffered chars.

Behaviour:
- Reset, synchronous active-high, sampled at posedge: state=IDLE, count=0, idx=0, char=0, valid=0, done=0, is_id=0, full=0. Buffer contents are don't-care.
- Reset mid-transmission aborts at once. Valid is 0 in the cycle after the reset edge, and no done pulse is produced.
- Char classes:
  - letter: 65..90 or 97..122
  - digit: 48..57
  - other: everything else
- States: IDLE, SEND, SEPR.
- IDLE:
  - wr_en with count<DEPTH: buf[count]<=wr_char, count+1.
  - wr_en with count==DEPTH: write dropped, nothing changes.
  - is_id update on each accepted write:
    - first char (count==0): is_id <= (class==letter).
    - later chars: is_id <= is_id & (class!=other).
  - start with count>0: go to SEND, idx<=0. Start has priority over wr_en in the same cycle; the write is dropped.
  - start with count==0: ignored, stay in IDLE.
- SEND:
  - valid=1, char=buf[idx].
  - valid is driven from registers only; there is no combinational path from ready to valid or char.
  - Beat = valid&&ready. On a beat: if idx==count-1 go to SEPR, else idx+1.
  - Without ready, char and valid hold stable.
- SEPR:
  - valid=1, char=SEP_CHAR.
  - On a beat: go to IDLE, pulse done for one cycle, clear count, idx and is_id.
- Busy behaviour: wr_en and start are ignored while busy; the buffer is frozen during transmission.
- Latency: start accepted at edge k puts valid=1 with buf[0] after edge k. With ready held at 1, count+1 beats take count+1 consecutive cycles, and done is high in the cycle after the separator beat.
- full is combinational from count; count is registered.

Decomposition:
- Shared package (id_pkg) holds:
  - char class constants: LETTER_UC_LO/HI, LETTER_LC_LO/HI, DIGIT_LO/HI;
  - 2-bit class encoding: OTHER=0, LETTER=1, DIGIT=2;
  - state encodings.
- Sub-module char_class: combinational classifier, 8-bit char in, 2-bit class out. It is shared with the recognizer so both ends agree on the classes.

Test Plan:
- Load 97,49 ("a1"), start, ready=1 → char 97, 49, 32 on three consecutive cycles with valid=1; done pulses once on the following cycle; is_id=1 before start; count=0 after done.
- Load 49,97 ("1a") → is_id=0. Load 65,36 ("A$") → is_id=0. Start, ready=1 → 65, 36, 32 still transmitted.
- Backpressure: load "xy", start, ready pattern 0,1,0,0,1,1 → char holds 120 for the first cycle, holds 121 across the two stalled cycles, and each char is accepted exactly once.
- Overflow with DEPTH=8: write 9 letters → full=1 after the 8th write, count stays 8, 9th char absent; transmission gives 8 chars plus 32.
- Start with count=0 → busy stays 0 and valid stays 0. Start and wr_en in the same cycle with count=1 → SEND entered, count stays 1.
- Reset asserted on the 2nd beat of a 3-char send → valid=0, busy=0, count=0 after the reset edge; no done pulse; a fresh load and send then works.
